// File: rtl/seg7_pkg.sv
// Shared state type, hex segment table and output polarity helper for the
// multiplexed 7-segment scan driver.
package seg7_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    // Active-high {g,f,e,d,c,b,a}; b and d are lower case, A/C/E/F upper case.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic polarity(input logic x, input logic active_low);
        return x ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with per-slot PWM brightness, anode dead
// time and a frame-synchronous load handshake for tear-free updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PHASE_CYCLES = 3125,
    parameter int DEAD_CYCLES  = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness,
    output logic                    load_ack,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PC_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int DC_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PC_W-1:0]  PHASE_LAST = PC_W'(PHASE_CYCLES - 1);
    localparam logic [DC_W-1:0]  DEAD_LAST  = DC_W'(DEAD_CYCLES - 1);

    state_t            state, state_nx;
    logic [DC_W-1:0]   dead_cnt, dead_cnt_nx;
    logic [PC_W-1:0]   phase_cnt, phase_cnt_nx;
    logic [3:0]        phase, phase_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [3:0]        bright, bright_nx;
    logic              frame_end;

    logic [4*NUM_DIGITS-1:0] disp_digits, pend_digits;
    logic [NUM_DIGITS-1:0]   disp_blank, pend_blank;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic                    pend_valid;

    logic [3:0]            nib_sel;
    logic                  blank_sel, dp_sel, lit;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [6:0]            seg_nx;
    logic                  dp_nx;

    always_comb begin
        state_nx     = state;
        dead_cnt_nx  = dead_cnt;
        phase_cnt_nx = phase_cnt;
        phase_nx     = phase;
        idx_nx       = idx;
        bright_nx    = bright;
        frame_end    = 1'b0;
        case (state)
            ST_DEAD: begin
                if (dead_cnt == DEAD_LAST) begin
                    state_nx    = ST_ON;
                    dead_cnt_nx = '0;
                    bright_nx   = brightness;
                end else begin
                    dead_cnt_nx = dead_cnt + DC_W'(1);
                end
            end
            ST_ON: begin
                if (phase_cnt == PHASE_LAST) begin
                    phase_cnt_nx = '0;
                    if (phase == 4'd15) begin
                        phase_nx = 4'd0;
                        state_nx = ST_DEAD;
                        if (idx == IDX_LAST) begin
                            idx_nx    = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end else begin
                        phase_nx = phase + 4'd1;
                    end
                end else begin
                    phase_cnt_nx = phase_cnt + PC_W'(1);
                end
            end
            default: state_nx = ST_DEAD;
        endcase
    end

    // Output registers are loaded from the next-cycle position so they line
    // up with the state they describe rather than lagging it by one cycle.
    always_comb begin
        nib_sel   = 4'd0;
        blank_sel = 1'b1;
        dp_sel    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IDX_W'(i)) begin
                nib_sel   = disp_digits[4*i +: 4];
                blank_sel = disp_blank[i];
                dp_sel    = disp_dp[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    always_comb begin
        lit = (state_nx == ST_ON) && (phase_nx <= bright_nx) && !blank_sel;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nx[i] = polarity(lit && (idx_nx == IDX_W'(i)), ACTIVE_LOW);
        end
        for (int i = 0; i < 7; i++) begin
            seg_nx[i] = polarity(lit && dec_seg[i], ACTIVE_LOW);
        end
        dp_nx = polarity(lit && dp_sel, ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_DEAD;
            dead_cnt  <= '0;
            phase_cnt <= '0;
            phase     <= 4'd0;
            idx       <= '0;
            bright    <= 4'd0;
        end else begin
            state     <= state_nx;
            dead_cnt  <= dead_cnt_nx;
            phase_cnt <= phase_cnt_nx;
            phase     <= phase_nx;
            idx       <= idx_nx;
            bright    <= bright_nx;
        end
    end

    // A load coinciding with frame end still lands in pending for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_digits <= '0;
            disp_blank  <= '1;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_blank  <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            load_ack    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_end;
            load_ack   <= frame_end && pend_valid;
            if (frame_end && pend_valid) begin
                disp_digits <= pend_digits;
                disp_blank  <= pend_blank;
                disp_dp     <= pend_dp;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_blank  <= blank_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= {NUM_DIGITS{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
            dp  <= dp_nx;
        end
    end

endmodule
